// File: rtl/delta_decoder_pkg.sv
// Shared types and constants for the delta decoder.
// The state enumeration and the error-counter width live here.
package delta_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam int ERR_COUNT_WIDTH = 8;

endpackage

// File: rtl/delta_clamp.sv
// Range check and output narrowing for a widened delta.
// Saturates when DELTA_DECODER_SAT_EN is defined, otherwise keeps the low bits (wrap).
module delta_clamp #(
    parameter int IN_WIDTH = 14
) (
    input  logic signed [IN_WIDTH+1:0] delta,
    output logic signed [IN_WIDTH-1:0] d,
    output logic                       out_of_range
);

    logic [2:0] top_bits;

    // In range exactly when the three top bits are all copies of the sign bit.
    assign top_bits     = delta[IN_WIDTH+1:IN_WIDTH-1];
    assign out_of_range = !((top_bits == 3'b000) || (top_bits == 3'b111));

`ifdef DELTA_DECODER_SAT_EN
    always_comb begin
        d = delta[IN_WIDTH-1:0];
        if (out_of_range) begin
            d = delta[IN_WIDTH+1] ? {1'b1, {(IN_WIDTH-1){1'b0}}}
                                  : {1'b0, {(IN_WIDTH-1){1'b1}}};
        end
    end
`else
    assign d = delta[IN_WIDTH-1:0];
`endif

endmodule

// File: rtl/delta_decoder.sv
// Rebuilds signed deltas from a stream of running sums, flagging untrusted results.
// Optional build macro: DELTA_DECODER_SAT_EN (saturate out-of-range deltas instead of wrapping).
module delta_decoder
    import delta_decoder_pkg::*;
#(
    parameter int IN_WIDTH = 14
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [IN_WIDTH:0]          init,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_load,
    input  logic signed [IN_WIDTH:0]          in_y,
    input  logic                              in_overflow,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic signed [IN_WIDTH-1:0]        out_d,
    output logic                              out_load,
    output logic                              out_err,
    output logic [ERR_COUNT_WIDTH-1:0]        err_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and the output stage accepts a new sample whenever
    // it is empty or is being drained in the same cycle.

    state_t                   state, next_state;
    logic signed [IN_WIDTH:0] prev;
    logic signed [IN_WIDTH+1:0] delta;
    logic signed [IN_WIDTH-1:0] clamp_d;
    logic                     out_of_range;
    logic                     in_xfer, out_xfer;
    logic                     next_err;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Both operands sign-extended by one bit so the difference cannot overflow.
    assign delta = {in_y[IN_WIDTH], in_y}
                 - (in_load ? {init[IN_WIDTH], init} : {prev[IN_WIDTH], prev});

    delta_clamp #(.IN_WIDTH(IN_WIDTH)) u_clamp (
        .delta        (delta),
        .d            (clamp_d),
        .out_of_range (out_of_range)
    );

    always_comb begin
        next_state = state;
        next_err   = 1'b0;
        if (in_xfer) begin
            if (in_overflow) begin
                next_state = FAULT;
                next_err   = 1'b1;
            end else if (in_load) begin
                next_state = RUN;
            end else begin
                next_state = RUN;
                next_err   = (state != RUN);
            end
            next_err = next_err || out_of_range;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            prev  <= '0;
        end else begin
            state <= next_state;
            if (in_xfer) prev <= in_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_d     <= '0;
            out_load  <= 1'b0;
            out_err   <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_d     <= clamp_d;
            out_load  <= in_load;
            out_err   <= next_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (out_xfer && out_err && (err_count != '1)) begin
            err_count <= err_count + ERR_COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_delta_decoder.sv
// Self-checking bench for delta_decoder: directed vectors plus a per-cycle scoreboard model.
module tb_delta_decoder;
    import delta_decoder_pkg::*;

    localparam int W = 14;
    localparam int DMAX = (1 <<< (W - 1)) - 1;
    localparam int DMIN = -(1 <<< (W - 1));

    logic                clk;
    logic                reset;
    logic signed [W:0]   init;
    logic                in_valid;
    logic                in_ready;
    logic                in_load;
    logic signed [W:0]   in_y;
    logic                in_overflow;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_d;
    logic                out_load;
    logic                out_err;
    logic [7:0]          err_count;

    int n_err = 0;
    int n_chk = 0;

    delta_decoder #(.IN_WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_load     (in_load),
        .in_y        (in_y),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_d       (out_d),
        .out_load    (out_load),
        .out_err     (out_err),
        .err_count   (err_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard model: entries are {load, err, d}
    logic [W+1:0] exp_q[$];
    int           m_prev;
    bit           m_trusted;
    int           m_count;
    int           m_base, m_delta;
    logic [31:0]  m_dv;
    logic [W-1:0] m_d;
    bit           m_e, m_rdy;
    logic [W+1:0] ent;

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_prev    = 0;
            m_trusted = 1'b0;
            m_count   = 0;
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_d", int'(out_d), 0);
            chk("rst_out_load", int'(out_load), 0);
            chk("rst_out_err", int'(out_err), 0);
            chk("rst_err_count", int'(err_count), 0);
            chk("rst_in_ready", int'(in_ready), 1);
        end else begin
            chk("sb_in_ready", int'(in_ready), int'(exp_q.size() == 0 || out_ready));
            chk("sb_out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("sb_err_count", int'(err_count), m_count);
            if (exp_q.size() != 0) begin
                ent = exp_q[0];
                chk("sb_out_d", int'(out_d), int'($signed(ent[W-1:0])));
                chk("sb_out_err", int'(out_err), int'(ent[W]));
                chk("sb_out_load", int'(out_load), int'(ent[W+1]));
            end
            // effects of the coming rising edge
            m_rdy = (exp_q.size() == 0) || out_ready;
            if (exp_q.size() != 0 && out_ready) begin
                if (exp_q[0][W] && m_count < 255) m_count++;
                void'(exp_q.pop_front());
            end
            if (in_valid && m_rdy) begin
                m_base  = in_load ? int'(init) : m_prev;
                m_delta = int'(in_y) - m_base;
                m_e = in_overflow || (!in_load && !m_trusted) || m_delta < DMIN || m_delta > DMAX;
                m_dv = m_delta;
                m_d  = m_dv[W-1:0];
`ifdef DELTA_DECODER_SAT_EN
                if (m_delta > DMAX) m_d = W'(DMAX);
                if (m_delta < DMIN) m_d = W'(DMIN);
`endif
                exp_q.push_back({in_load, m_e, m_d});
                m_prev    = int'(in_y);
                m_trusted = !in_overflow;
            end
        end
    end

    // driver: call at 2 time units after a rising edge with out_ready=1
    task automatic send(input int y, input bit ld, input bit ovf,
                        input int exp_d, input bit exp_ld, input bit exp_err, input string nm);
        in_valid    = 1'b1;
        in_y        = (W+1)'(y);
        in_load     = ld;
        in_overflow = ovf;
        @(posedge clk);
        #2;
        in_valid    = 1'b0;
        in_load     = 1'b0;
        in_overflow = 1'b0;
        chk({nm, "_d"}, int'(out_d), exp_d);
        chk({nm, "_load"}, int'(out_load), int'(exp_ld));
        chk({nm, "_err"}, int'(out_err), int'(exp_err));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset       = 1'b0;
        init        = '0;
        in_valid    = 1'b0;
        in_load     = 1'b0;
        in_y        = '0;
        in_overflow = 1'b0;
        out_ready   = 1'b1;
        #1;
        chk("state_in_reset", int'(dut.state), int'(IDLE));
        do_reset();

        // non-load sample straight out of reset
        send(40, 1'b0, 1'b0, 40, 1'b0, 1'b1, "idle_y40");
        send(41, 1'b0, 1'b0, 1, 1'b0, 1'b0, "run_y41");
        chk("cnt_after_idle", int'(err_count), 1);

        // load sequence
        send(0, 1'b1, 1'b0, 0, 1'b1, 1'b0, "seq_0");
        send(12, 1'b0, 1'b0, 12, 1'b0, 1'b0, "seq_12");
        send(5, 1'b0, 1'b0, -7, 1'b0, 1'b0, "seq_5");
        send(7, 1'b0, 1'b0, 2, 1'b0, 1'b0, "seq_7");
        send(10, 1'b0, 1'b0, 3, 1'b0, 1'b0, "seq_10");

        // out-of-range delta 16000
        send(-8000, 1'b1, 1'b0, -8000, 1'b1, 1'b0, "big_base");
`ifdef DELTA_DECODER_SAT_EN
        send(8000, 1'b0, 1'b0, 8191, 1'b0, 1'b1, "big_delta");
`else
        send(8000, 1'b0, 1'b0, -384, 1'b0, 1'b1, "big_delta");
`endif

        // overflow then recovery
        do_reset();
        send(100, 1'b0, 1'b1, 100, 1'b0, 1'b1, "ovf_sample");
        send(5, 1'b0, 1'b0, -95, 1'b0, 1'b1, "after_fault");
        init = (W+1)'(1);
        send(3, 1'b1, 1'b0, 2, 1'b1, 1'b0, "reload");
        init = '0;
        chk("ovf_err_count", int'(err_count), 2);

        // backpressure
        in_valid = 1'b1; in_load = 1'b1; in_y = (W+1)'(10);
        @(posedge clk); #2;
        out_ready = 1'b0; in_load = 1'b0; in_y = (W+1)'(20);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_hold_d", int'(out_d), 10);
            chk("bp_hold_valid", int'(out_valid), 1);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_d20", int'(out_d), 10);
        in_y = (W+1)'(35);
        @(posedge clk); #2;
        chk("bp_d35", int'(out_d), 15);
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("bp_drained", int'(out_valid), 0);

        // reset between two accepted samples
        in_valid = 1'b1; in_load = 1'b1; in_y = (W+1)'(7);
        @(posedge clk); #2;
        in_valid = 1'b0; in_load = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_d", int'(out_d), 0);
        chk("mid_rst_load", int'(out_load), 0);
        chk("mid_rst_err", int'(out_err), 0);
        chk("mid_rst_cnt", int'(err_count), 0);
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_state", int'(dut.state), int'(IDLE));
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        send(9, 1'b0, 1'b0, 9, 1'b0, 1'b1, "post_rst");

        // err_count saturation
        in_valid = 1'b1; in_overflow = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_y = (W+1)'(i);
            @(posedge clk); #2;
        end
        in_valid = 1'b0; in_overflow = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("err_count_sat", int'(err_count), 255);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
